// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames one accepted word as start, data (LSB first),
// optional parity and stop bits, advancing exactly one bit per baud_pulse.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_pulse,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 frame_done
);
    localparam int               IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             PAR_EN    = (PARITY_EN != 0);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARMED  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    logic [2:0]           state;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    // Handshake: a word is accepted on any clk edge with tx_valid & tx_ready;
    // tx_ready is high only in IDLE, so a held tx_valid waits for the next IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_ready   <= 1'b1;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // baud_pulse is ignored here; the start bit waits for the next tick
                    if (tx_valid && tx_ready) begin
                        shift_reg  <= tx_data;
                        parity_bit <= (^tx_data) ^ PAR_INV;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    if (baud_pulse) begin
                        tx_line <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_pulse) begin
                        tx_line   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (baud_pulse) begin
                        if (bit_idx != LAST_IDX) begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx_line   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end else if (PAR_EN) begin
                            tx_line <= parity_bit;
                            state   <= PARITY;
                        end else begin
                            tx_line  <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (baud_pulse) begin
                        tx_line  <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (baud_pulse) begin
                        if (stop_cnt != LAST_STOP) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            tx_busy    <= 1'b0;
                            tx_ready   <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three parameterisations, a line monitor that decodes
// frames per baud period, and a reference model that builds expected frames.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] tx_valid = 3'b000;
    logic [2:0] line_w, ready_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;

    // DUT 0: 8N1, DUT 1: 8E2, DUT 2: 5O1
    int cfg_db[3] = '{8, 8, 5};
    int cfg_pe[3] = '{0, 1, 1};
    int cfg_po[3] = '{0, 0, 1};
    int cfg_sb[3] = '{1, 2, 1};

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
        .tx_valid(tx_valid[0]), .tx_ready(ready_w[0]), .tx_line(line_w[0]),
        .tx_busy(busy_w[0]), .frame_done(done_w[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data),
        .tx_valid(tx_valid[1]), .tx_ready(ready_w[1]), .tx_line(line_w[1]),
        .tx_busy(busy_w[1]), .frame_done(done_w[1]));
    uart_tx_ctrl #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_data(tx_data[4:0]),
        .tx_valid(tx_valid[2]), .tx_ready(ready_w[2]), .tx_line(line_w[2]),
        .tx_busy(busy_w[2]), .frame_done(done_w[2]));

    // Clock and baud generator (inputs change 1 time unit after the falling edge)
    always #5 clk = ~clk;

    int baud_div = 16;
    int baud_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            baud_cnt   = (baud_cnt + 1 >= baud_div) ? 0 : baud_cnt + 1;
            baud_pulse = (baud_cnt == 0);
        end
    end

    // Monitor state: samples the selected DUT on each falling edge
    int          sel = 0;
    int          frame_len = 10;
    bit          mon_on = 1'b0;
    bit          collecting = 1'b0;
    bit          in_frame = 1'b0;
    int          bit_cnt = 0;
    int          gap_cnt = 0;
    int          since_start = 0;
    logic [15:0] cur_frame = '0;
    logic [15:0] rx_q[$];
    int          gap_q[$];
    int          done_pos_q[$];
    int          done_cnt = 0, acc_cnt = 0, glitch_cnt = 0, done_wide = 0, done_bad = 0;
    logic        last_line = 1'b1, last_done = 1'b0, last_ready = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (baud_pulse) begin
                    if (in_frame) since_start++;
                    if (!collecting) begin
                        if (line_w[sel] == 1'b0) begin
                            collecting  = 1'b1;
                            in_frame    = 1'b1;
                            bit_cnt     = 1;
                            cur_frame   = '0;
                            since_start = 0;
                            gap_q.push_back(gap_cnt);
                        end else begin
                            gap_cnt++;
                        end
                    end else begin
                        cur_frame[bit_cnt] = line_w[sel];
                        bit_cnt++;
                        if (bit_cnt == frame_len) begin
                            rx_q.push_back(cur_frame);
                            collecting = 1'b0;
                            gap_cnt    = 0;
                        end
                    end
                end else if (line_w[sel] !== last_line) begin
                    glitch_cnt++;
                end
                if (done_w[sel]) begin
                    done_cnt++;
                    if (in_frame) done_pos_q.push_back(since_start);
                    in_frame = 1'b0;
                    if (ready_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0) done_bad++;
                end
                if (done_w[sel] && last_done) done_wide++;
                if (tx_valid[sel] && last_ready) acc_cnt++;
            end
            last_line  = line_w[sel];
            last_done  = done_w[sel];
            last_ready = ready_w[sel];
        end
    end

    task automatic mon_clear();
        rx_q.delete();
        gap_q.delete();
        done_pos_q.delete();
        collecting = 1'b0;
        in_frame   = 1'b0;
        gap_cnt    = 0;
        done_cnt   = 0;
        acc_cnt    = 0;
        glitch_cnt = 0;
        done_wide  = 0;
        done_bad   = 0;
    endtask

    // Reference model: start 0, data LSB first, parity over the data bits, stop 1s
    function automatic logic [15:0] model_frame(input logic [7:0] d, input int idx);
        logic [15:0] f;
        int ones;
        f    = '0;
        ones = 0;
        for (int i = 0; i < cfg_db[idx]; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (cfg_pe[idx] != 0) f[1+cfg_db[idx]] = ((ones % 2) == 1) ^ (cfg_po[idx] != 0);
        for (int j = 0; j < cfg_sb[idx]; j++) f[1+cfg_db[idx]+cfg_pe[idx]+j] = 1'b1;
        return f;
    endfunction

    function automatic int flen(input int idx);
        return 1 + cfg_db[idx] + cfg_pe[idx] + cfg_sb[idx];
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, output bit ok);
        int base;
        base        = acc_cnt;
        tx_data     = b;
        tx_valid[d] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (acc_cnt != base) break;
        end
        tx_valid[d] = 1'b0;
        ok = (acc_cnt != base);
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (line_w !== 3'b111 || ready_w !== 3'b111 || busy_w !== 3'b000 || done_w !== 3'b000) begin
            errors++;
            $display("FAIL reset: line=%b ready=%b busy=%b done=%b, required 111 111 000 000",
                     line_w, ready_w, busy_w, done_w);
        end
        rst = 1'b0;
        tick();
        mon_clear();
        mon_on = 1'b1;
    endtask

    task automatic test_idle();
        sel      = 0;
        baud_div = 4;
        mon_clear();
        for (int c = 0; c < 48; c++) begin
            tick();
            checks++;
            if (line_w !== 3'b111 || busy_w !== 3'b000 || ready_w !== 3'b111) begin
                errors++;
                $display("FAIL idle: line=%b busy=%b ready=%b, required 111 000 111", line_w, busy_w, ready_w);
            end
        end
        checks++;
        if (done_cnt != 0 || acc_cnt != 0) begin
            errors++;
            $display("FAIL idle_events: done=%0d accepts=%0d, required 0 0", done_cnt, acc_cnt);
        end
    endtask

    task automatic test_frames(input int d, input int n, input logic [7:0] first);
        logic [7:0]  b;
        logic [15:0] exp_f, got_f;
        bit          ok;
        int          pos;
        sel       = d;
        frame_len = flen(d);
        baud_div  = 16;
        tick();
        mon_clear();
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? first : 8'($urandom_range(0, 255));
            if (i > 0) baud_div = $urandom_range(2, 20);
            send_byte(d, b, ok);
            if (ok) wait_done(i + 1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame_timeout: dut=%0d byte=%h done_cnt=%0d, required %0d", d, b, done_cnt, i + 1);
                return;
            end
            exp_f = model_frame(b, d);
            got_f = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL frame_bits: dut=%0d byte=%h got %b required %b", d, b, got_f, exp_f);
            end
            pos = (done_pos_q.size() > 0) ? done_pos_q.pop_front() : -1;
            checks++;
            if (pos != frame_len) begin
                errors++;
                $display("FAIL done_position: dut=%0d periods from start=%0d, required %0d", d, pos, frame_len);
            end
        end
        repeat (3) tick();
        checks++;
        if (glitch_cnt != 0 || done_wide != 0 || done_bad != 0 || done_cnt != n) begin
            errors++;
            $display("FAIL frame_timing: dut=%0d glitches=%0d wide_done=%0d ready_busy_bad=%0d dones=%0d, required 0 0 0 %0d",
                     d, glitch_cnt, done_wide, done_bad, done_cnt, n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp_q[$];
        logic [15:0] got_f, exp_f;
        int issued, g;
        bit ok;
        sel       = 0;
        frame_len = flen(0);
        baud_div  = 16;
        tick();
        mon_clear();
        q           = '{8'h11, 8'h22, 8'h33};
        exp_q       = q;
        issued      = 0;
        tx_data     = q[0];
        tx_valid[0] = 1'b1;
        for (int c = 0; c < 3000 && issued < 3; c++) begin
            tick();
            issued = acc_cnt;
            if (issued < 3) tx_data = q[issued];
        end
        tx_valid[0] = 1'b0;
        wait_done(3, ok);
        repeat (20) tick();
        checks++;
        if (!ok || acc_cnt != 3 || done_cnt != 3) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d dones=%0d, required 3 3", acc_cnt, done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            exp_f = model_frame(exp_q[i], 0);
            got_f = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %b required %b", i, got_f, exp_f);
            end
        end
        // The only high period between frames is the ARMED wait after frame_done
        void'(gap_q.pop_front());
        for (int i = 1; i < 3; i++) begin
            g = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
            checks++;
            if (g != 1) begin
                errors++;
                $display("FAIL b2b_gap%0d: idle periods=%0d, required 1", i, g);
            end
        end
    endtask

    task automatic test_accept_on_baud();
        logic [7:0]  b;
        logic [15:0] got_f;
        int k;
        bit ok;
        sel       = 0;
        frame_len = flen(0);
        baud_div  = 16;
        tick();
        mon_clear();
        for (int c = 0; c < 64 && baud_pulse !== 1'b1; c++) tick();
        b           = 8'($urandom_range(0, 255));
        tx_data     = b;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        checks++;
        if (ready_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || line_w[0] !== 1'b1 || acc_cnt != 1) begin
            errors++;
            $display("FAIL accept_on_baud: ready=%b busy=%b line=%b accepts=%0d, required 0 1 1 1",
                     ready_w[0], busy_w[0], line_w[0], acc_cnt);
        end
        k = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            k++;
            if (line_w[0] === 1'b0) break;
        end
        checks++;
        if (k != baud_div) begin
            errors++;
            $display("FAIL start_delay: start bit after %0d clks, required %0d", k, baud_div);
        end
        wait_done(1, ok);
        got_f = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
        checks++;
        if (!ok || got_f !== model_frame(b, 0)) begin
            errors++;
            $display("FAIL accept_on_baud_frame: got %b required %b", got_f, model_frame(b, 0));
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        sel       = 0;
        frame_len = flen(0);
        baud_div  = 16;
        tick();
        mon_clear();
        send_byte(0, 8'($urandom_range(0, 255)), ok);
        // bit_cnt reaches 6 once data bit 4 is on the line
        for (int c = 0; c < 400 && !(collecting && bit_cnt == 6); c++) tick();
        repeat (3) tick();
        mon_on = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (line_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: line=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     line_w[0], ready_w[0], busy_w[0], done_w[0]);
        end
        mon_clear();
        mon_on = 1'b1;
        repeat (64) tick();
        checks++;
        if (done_cnt != 0 || busy_w[0] !== 1'b0 || rx_q.size() != 0 || glitch_cnt != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: dones=%0d busy=%b frames=%0d glitches=%0d, required 0 0 0 0",
                     done_cnt, busy_w[0], rx_q.size(), glitch_cnt);
        end
        test_frames(0, 1, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frames(0, 4, 8'hA5);
        test_frames(1, 3, 8'h07);
        test_frames(2, 3, 8'h07);
        test_back_to_back();
        test_accept_on_baud();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
